// File: rtl/eth_mac_tx_if.sv
// rtl/eth_mac_tx_if.sv - user-side and PCS-side byte streams of the TX MAC framer
interface eth_mac_tx_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_eof;

  // MAC side: consumes the user stream, produces the PCS stream
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_eof
  );

  // Environment side: user source plus PCS sink
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_eof
  );
endinterface

// File: rtl/eth_mac_tx.sv
// rtl/eth_mac_tx.sv - Ethernet TX framer: zero padding, CRC-32 FCS append, inter-frame gap
module eth_mac_tx #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  eth_mac_tx_if.slave  bus,
  output logic         frame_done,
  output logic         underrun
);

  typedef enum logic [2:0] {IDLE, PAYLOAD, PAD, FCS, IFG} state_t;

  localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME);
  // The IDLE cycle that accepts the next first byte is itself an empty output
  // cycle, so the IFG state lasts one cycle less than the visible gap.
  localparam logic [15:0] IFG_LAST = (IFG_CYCLES > 2) ? 16'(IFG_CYCLES - 2) : 16'd0;

  state_t      state, state_nxt;
  logic        m_valid_q, m_valid_nxt;
  logic [7:0]  m_data_q, m_data_nxt;
  logic        m_eof_q, m_eof_nxt;
  logic [31:0] crc, crc_nxt;
  logic [10:0] len, len_nxt;
  logic [1:0]  fcs_idx, fcs_idx_nxt;
  logic [15:0] ifg_cnt, ifg_cnt_nxt;
  logic        frame_done_nxt, underrun_nxt;
  logic        alive;
  logic        ld;
  logic        s_ready;
  logic        s_hs;
  logic [11:0] len_p1;
  logic [10:0] len_inc;
  logic [31:0] crc_out;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  assign ld       = ~m_valid_q | bus.m_ready;
  assign s_ready  = alive & ld & ((state == IDLE) | (state == PAYLOAD));
  assign s_hs     = bus.s_valid & s_ready;
  assign len_p1   = {1'b0, len} + 12'd1;
  assign len_inc  = (len == 11'h7FF) ? len : len + 11'd1;
  assign crc_out  = ~crc;
  assign fcs_byte = crc_out[{fcs_idx, 3'b000} +: 8];

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_eof   = m_eof_q;

  // Next-state and datapath: every load happens only when the output register is free
  always_comb begin
    state_nxt      = state;
    m_valid_nxt    = m_valid_q;
    m_data_nxt     = m_data_q;
    m_eof_nxt      = m_eof_q;
    crc_nxt        = crc;
    len_nxt        = len;
    fcs_idx_nxt    = fcs_idx;
    ifg_cnt_nxt    = ifg_cnt;
    frame_done_nxt = 1'b0;
    underrun_nxt   = 1'b0;
    if (ld) begin
      m_valid_nxt = 1'b0;
    end
    case (state)
      IDLE: begin
        if (s_hs) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = bus.s_data;
          m_eof_nxt   = 1'b0;
          crc_nxt     = crc_byte(32'hFFFFFFFF, bus.s_data);
          len_nxt     = 11'd1;
          fcs_idx_nxt = 2'd0;
          if (bus.s_last) begin
            state_nxt = (12'd1 < MIN_LEN) ? PAD : FCS;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (s_hs) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = bus.s_data;
          crc_nxt     = crc_byte(crc, bus.s_data);
          len_nxt     = len_inc;
          if (bus.s_last) begin
            state_nxt = (len_p1 < MIN_LEN) ? PAD : FCS;
          end
        end else if (ld && !bus.s_valid) begin
          underrun_nxt = 1'b1;
        end
      end
      PAD: begin
        if (ld) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = 8'h00;
          crc_nxt     = crc_byte(crc, 8'h00);
          len_nxt     = len_inc;
          if (len_p1 >= MIN_LEN) begin
            state_nxt = FCS;
          end
        end
      end
      FCS: begin
        if (m_valid_q && m_eof_q) begin
          if (bus.m_ready) begin
            m_eof_nxt      = 1'b0;
            ifg_cnt_nxt    = 16'd0;
            frame_done_nxt = 1'b1;
            state_nxt      = IFG;
          end
        end else if (ld) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = fcs_byte;
          m_eof_nxt   = (fcs_idx == 2'd3);
          fcs_idx_nxt = fcs_idx + 2'd1;
        end
      end
      IFG: begin
        if (ifg_cnt >= IFG_LAST) begin
          state_nxt = IDLE;
        end else begin
          ifg_cnt_nxt = ifg_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; async clear abandons any frame in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'h00;
      m_eof_q    <= 1'b0;
      crc        <= 32'hFFFFFFFF;
      len        <= 11'd0;
      fcs_idx    <= 2'd0;
      ifg_cnt    <= 16'd0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      alive      <= 1'b0;
    end else begin
      state      <= state_nxt;
      m_valid_q  <= m_valid_nxt;
      m_data_q   <= m_data_nxt;
      m_eof_q    <= m_eof_nxt;
      crc        <= crc_nxt;
      len        <= len_nxt;
      fcs_idx    <= fcs_idx_nxt;
      ifg_cnt    <= ifg_cnt_nxt;
      frame_done <= frame_done_nxt;
      underrun   <= underrun_nxt;
      alive      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// tb/tb_eth_mac_tx.sv - randomized self-checking bench for eth_mac_tx against a table-driven frame model
module tb_eth_mac_tx;
  localparam int MIN_FRAME  = 60;
  localparam int IFG_CYCLES = 12;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_done, underrun, frame_done0, underrun0;

  always #5 clk = ~clk;

  eth_mac_tx_if u ();
  eth_mac_tx_if u0 ();

  eth_mac_tx #(.MIN_FRAME(MIN_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .bus(u.slave), .frame_done(frame_done), .underrun(underrun)
  );

  eth_mac_tx #(.MIN_FRAME(0), .IFG_CYCLES(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(u0.slave), .frame_done(frame_done0), .underrun(underrun0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];
  logic [7:0]  frame[$];
  logic [8:0]  exp_q[$];

  task automatic build_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  task automatic model_add(input int min_len);
    logic [7:0]  b[$];
    logic [31:0] c;
    b = frame;
    while (b.size() < min_len) b.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
      exp_q.push_back({1'b0, b[i]});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
  endtask

  task automatic make_frame(input int n);
    frame.delete();
    repeat (n) frame.push_back(8'($urandom));
  endtask

  // ---------------- PCS-side ready generator ----------------
  bit bp_on = 1'b0;
  always @(negedge clk) u.m_ready = bp_on ? ($urandom_range(0, 2) != 0) : 1'b1;

  // ---------------- output monitor (main DUT) ----------------
  logic [8:0] got[$];
  int   cyc = 0, done_cnt = 0, und_cnt = 0, last_gap = -1, eof_cyc = -1;
  logic gap_open = 1'b0, prev_stall = 1'b0, prev_eof_hs = 1'b0;
  logic [8:0] prev_out = '0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (reset_n) begin
      if (prev_stall) begin
        chk("hold_valid", u.m_valid, 1);
        chk("hold_data", {u.m_eof, u.m_data}, prev_out);
      end
      if (u.m_valid && !u.m_ready) chk("bp_s_ready", u.s_ready, 0);
      if (frame_done) begin
        done_cnt++;
        chk("done_after_eof", prev_eof_hs, 1);
      end
      if (underrun) und_cnt++;
      if (u.m_valid && gap_open) begin
        last_gap = cyc - eof_cyc - 1;
        gap_open = 1'b0;
      end
      if (u.m_valid && u.m_ready) begin
        got.push_back({u.m_eof, u.m_data});
        if (u.m_eof) begin
          eof_cyc  = cyc;
          gap_open = 1'b1;
        end
      end
      prev_eof_hs = u.m_valid & u.m_ready & u.m_eof;
      prev_stall  = u.m_valid & ~u.m_ready;
      prev_out    = {u.m_eof, u.m_data};
    end else begin
      prev_stall  = 1'b0;
      prev_eof_hs = 1'b0;
      gap_open    = 1'b0;
    end
  end

  // ---------------- output monitor (no-padding DUT) ----------------
  logic [8:0] got0[$];
  int cyc0 = 0, eof0_cyc = -1, done0_cyc = -1;

  always begin
    @(negedge clk);
    #4;
    cyc0++;
    if (reset_n) begin
      if (frame_done0) done0_cyc = cyc0;
      if (u0.m_valid && u0.m_ready) begin
        got0.push_back({u0.m_eof, u0.m_data});
        if (u0.m_eof) eof0_cyc = cyc0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int stall_at, input int stall_n);
    int idx = 0, stalled = 0, guard = 0;
    while (idx < frame.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (idx == stall_at && stalled < stall_n) begin
        u.s_valid = 1'b0;
        u.s_last  = 1'b0;
        stalled++;
      end else begin
        u.s_valid = 1'b1;
        u.s_data  = frame[idx];
        u.s_last  = (idx == frame.size() - 1);
      end
      #4;
      if (u.s_valid && u.s_ready) idx++;
    end
    chk("send_timeout", (guard < 3000), 1);
  endtask

  task automatic idle();
    @(negedge clk);
    u.s_valid = 1'b0;
    u.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard = 0;
    while (done_cnt < target && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("done_timeout", (done_cnt >= target), 1);
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] crc_exp [13];
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [8:0] fcs1;
    int ub, guard, done_before;

    u.s_valid = 1'b0; u.s_last = 1'b0; u.s_data = 8'h00;
    u0.s_valid = 1'b0; u0.s_last = 1'b0; u0.s_data = 8'h00; u0.m_ready = 1'b1;
    reset_n = 1'b0;
    build_tab();

    // reset state
    repeat (3) @(negedge clk);
    #4;
    chk("rst_s_ready", u.s_ready, 0);
    chk("rst_m_valid", u.m_valid, 0);
    chk("rst_m_data", u.m_data, 0);
    chk("rst_m_eof", u.m_eof, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_s_ready0", u0.s_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #4;
    chk("rel_s_ready_pre", u.s_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_s_ready", u.s_ready, 1);

    // known-answer FCS with padding disabled
    crc_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      u0.s_valid = 1'b1;
      u0.s_data  = 8'h31 + 8'(i);
      u0.s_last  = (i == 8);
      #4;
      chk("crc_s_ready", u0.s_ready, 1);
    end
    @(negedge clk);
    u0.s_valid = 1'b0;
    u0.s_last  = 1'b0;
    guard = 0;
    while (done0_cyc < 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("crc_len", got0.size(), 13);
    for (int i = 0; i < 13 && i < got0.size(); i++) chk("crc_byte", got0[i], {(i == 12), crc_exp[i]});
    chk("crc_done_delay", done0_cyc, eof0_cyc + 1);
    chk("crc_underrun", underrun0, 0);

    // short frame padded to MIN_FRAME
    make_frame(14);
    model_add(MIN_FRAME);
    send(-1, 0);
    idle();
    wait_done(1);
    check_out("pad");

    // random backpressure on a 100-byte frame
    bp_on = 1'b1;
    make_frame(100);
    model_add(MIN_FRAME);
    send(-1, 0);
    idle();
    wait_done(2);
    bp_on = 1'b0;
    check_out("bp");
    chk("no_underrun_yet", und_cnt, 0);

    // back-to-back frames: gap between eof handshake and next first byte
    make_frame(20);
    model_add(MIN_FRAME);
    f1 = frame;
    make_frame(70);
    model_add(MIN_FRAME);
    f2 = frame;
    last_gap = -1;
    frame = f1;
    send(-1, 0);
    frame = f2;
    send(-1, 0);
    idle();
    wait_done(4);
    check_out("b2b");
    chk("ifg_gap", last_gap, IFG_CYCLES);

    // three-cycle user stall mid-payload
    make_frame(80);
    model_add(MIN_FRAME);
    ub = und_cnt;
    send(30, 3);
    idle();
    wait_done(5);
    check_out("stall");
    chk("underrun_cnt", und_cnt - ub, 3);

    // reset while FCS byte 1 is on the output
    make_frame(60);
    model_add(MIN_FRAME);
    fcs1 = exp_q[61];
    send(-1, 0);
    idle();
    guard = 0;
    while (got.size() < 61 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("pre_rst_fcs1", {u.m_valid, u.m_eof, u.m_data}, {1'b1, fcs1});
    done_before = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("midrst_m_valid", u.m_valid, 0);
    chk("midrst_m_eof", u.m_eof, 0);
    chk("midrst_m_data", u.m_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    got.delete();
    exp_q.delete();

    // one-byte frame after reset: padded and with a fresh FCS
    make_frame(1);
    model_add(MIN_FRAME);
    send(-1, 0);
    idle();
    wait_done(done_before + 1);
    repeat (3) @(negedge clk);
    check_out("after_rst");
    chk("no_done_on_reset", done_cnt, done_before + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
